// File: rtl/vm_ctrl_param.sv
// Parametrised vending controller: per-item stock/price tables, coin collection
// with an inactivity watchdog, cancel/refund, change return and supplier restock.
module vm_ctrl_param #(
  parameter int NUM_ITEMS = 8,
  parameter int SEL_W     = $clog2(NUM_ITEMS + 1),
  parameter int CNT_W     = 4,
  parameter int MAX_COUNT = 15,
  parameter int COST_W    = 8,
  parameter int BAL_W     = 16,
  parameter int TIMEOUT   = 512
) (
  input  logic              clk,
  input  logic              hrst_n,
  input  logic              srst,
  input  logic [1:0]        coins,
  input  logic [SEL_W-1:0]  buttons,
  input  logic              cancel,
  input  logic [SEL_W-1:0]  item,
  input  logic [CNT_W-1:0]  count,
  input  logic [COST_W-1:0] cost,
  input  logic              valid,
  output logic [SEL_W-1:0]  product,
  output logic [1:0]        status,
  output logic [BAL_W-1:0]  balance,
  output logic              change_valid,
  output logic [BAL_W-1:0]  credit,
  output logic [7:0]        info,
  output logic [2:0]        dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(NUM_ITEMS);
  localparam logic [CNT_W:0]   MAX_CNT  = (CNT_W + 1)'(MAX_COUNT);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_AVAIL = 2'b01;
  localparam logic [1:0] ST_OOS   = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_COLLECT = 3'd2,
    S_VEND    = 3'd3,
    S_REFUND  = 3'd4,
    S_RESTOCK = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [BAL_W-1:0]   credit_q, credit_d;
  logic [SEL_W-1:0]   product_q, product_d;
  logic [BAL_W-1:0]   balance_q, balance_d;
  logic               change_valid_q, change_valid_d;
  logic [1:0]         status_q, status_d;
  logic [7:0]         info_q, info_d;

  // Entry 0 is never written, so a code of 0 always reads as empty/unpriced.
  logic [CNT_W-1:0]   stock_q [0:NUM_ITEMS];
  logic [CNT_W-1:0]   stock_d [0:NUM_ITEMS];
  logic [COST_W-1:0]  price_q [0:NUM_ITEMS];
  logic [COST_W-1:0]  price_d [0:NUM_ITEMS];

  logic [BAL_W-1:0]   coin_val;
  logic [BAL_W:0]     credit_sum;
  logic [BAL_W-1:0]   credit_sat;
  logic [BAL_W-1:0]   price_sel;
  logic               item_ok;
  logic [SEL_W-1:0]   item_idx;
  logic [CNT_W:0]     rs_sum;
  logic               do_write;

  always_comb begin
    coin_val = '0;
    case (coins)
      2'b01:   coin_val = BAL_W'(5);
      2'b10:   coin_val = BAL_W'(10);
      2'b11:   coin_val = BAL_W'(25);
      default: coin_val = '0;
    endcase
  end

  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
  assign credit_sat = credit_sum[BAL_W] ? '1 : credit_sum[BAL_W-1:0];
  assign price_sel  = BAL_W'(price_q[sel_q]);
  assign item_ok    = (item != '0) && (item <= MAX_SEL);
  assign item_idx   = item_ok ? item : '0;
  assign rs_sum     = {1'b0, stock_q[item_idx]} + {1'b0, count};

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    timer_d        = timer_q;
    credit_d       = credit_q;
    product_d      = '0;
    balance_d      = '0;
    change_valid_d = 1'b0;
    status_d       = status_q;
    info_d         = info_q;
    stock_d        = stock_q;
    price_d        = price_q;
    do_write       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d  = S_RESTOCK;
          do_write = 1'b1;
        end else if (buttons != '0) begin
          if (buttons <= MAX_SEL) begin
            sel_d   = buttons;
            state_d = S_CHECK;
          end else begin
            status_d = ST_ERR;
          end
        end
      end
      S_CHECK: begin
        info_d = 8'(stock_q[sel_q]);
        if (stock_q[sel_q] == '0 || price_q[sel_q] == '0) begin
          status_d = ST_OOS;
          state_d  = S_IDLE;
        end else begin
          status_d = ST_AVAIL;
          timer_d  = TMR_LOAD;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A coin landing with cancel is credited so the refund returns it;
        // a coin landing on the vend decision cycle is dropped.
        if (cancel) begin
          credit_d = credit_sat;
          state_d  = S_REFUND;
        end else if (credit_q >= price_sel) begin
          state_d = S_VEND;
        end else if (coins != 2'b00) begin
          credit_d = credit_sat;
          timer_d  = TMR_LOAD;
        end else if (timer_q == '0) begin
          state_d = S_REFUND;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_VEND: begin
        product_d        = sel_q;
        balance_d        = credit_q - price_sel;
        change_valid_d   = 1'b1;
        stock_d[sel_q]   = stock_q[sel_q] - CNT_W'(1);
        credit_d         = '0;
        status_d         = ST_OK;
        state_d          = S_IDLE;
      end
      S_REFUND: begin
        balance_d      = credit_q;
        change_valid_d = 1'b1;
        credit_d       = '0;
        status_d       = ST_OK;
        state_d        = S_IDLE;
      end
      S_RESTOCK: begin
        if (valid) begin
          do_write = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Overflowing writes still take a new price; only the stock is protected.
    if (do_write) begin
      if (!item_ok) begin
        status_d = ST_ERR;
      end else begin
        if (cost != '0) price_d[item_idx] = cost;
        if (rs_sum > MAX_CNT) begin
          status_d = ST_ERR;
          info_d   = 8'(stock_q[item_idx]);
        end else begin
          stock_d[item_idx] = rs_sum[CNT_W-1:0];
          status_d          = ST_OK;
          info_d            = 8'(rs_sum[CNT_W-1:0]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!hrst_n) begin
      state_q        <= S_IDLE;
      sel_q          <= '0;
      timer_q        <= '0;
      credit_q       <= '0;
      product_q      <= '0;
      balance_q      <= '0;
      change_valid_q <= 1'b0;
      status_q       <= ST_OK;
      info_q         <= '0;
      for (int i = 0; i <= NUM_ITEMS; i++) begin
        stock_q[i] <= '0;
        price_q[i] <= '0;
      end
    end else if (srst) begin
      state_q        <= S_IDLE;
      sel_q          <= '0;
      timer_q        <= '0;
      credit_q       <= '0;
      product_q      <= '0;
      balance_q      <= '0;
      change_valid_q <= 1'b0;
      status_q       <= ST_OK;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      timer_q        <= timer_d;
      credit_q       <= credit_d;
      product_q      <= product_d;
      balance_q      <= balance_d;
      change_valid_q <= change_valid_d;
      status_q       <= status_d;
      info_q         <= info_d;
      stock_q        <= stock_d;
      price_q        <= price_d;
    end
  end

  assign product      = product_q;
  assign status       = status_q;
  assign balance      = balance_q;
  assign change_valid = change_valid_q;
  assign credit       = credit_q;
  assign info         = info_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_vm_ctrl_param.sv
// Self-checking bench for vm_ctrl_param: coin returns are scoreboarded through
// an expected queue; status/info/credit/timing are checked directly.
module tb_vm_ctrl_param;

  localparam int SEL_W   = 4;
  localparam int BAL_W   = 16;
  localparam int EW      = SEL_W + BAL_W;
  localparam int TIMEOUT = 512;

  logic             clk = 1'b0;
  logic             hrst_n = 1'b0;
  logic             srst = 1'b0;
  logic [1:0]       coins = '0;
  logic [SEL_W-1:0] buttons = '0;
  logic             cancel = 1'b0;
  logic [SEL_W-1:0] item = '0;
  logic [3:0]       count = '0;
  logic [7:0]       cost = '0;
  logic             valid = 1'b0;
  logic [SEL_W-1:0] product;
  logic [1:0]       status;
  logic [BAL_W-1:0] balance;
  logic             change_valid;
  logic [BAL_W-1:0] credit;
  logic [7:0]       info;
  logic [2:0]       dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  vm_ctrl_param dut (
    .clk(clk), .hrst_n(hrst_n), .srst(srst), .coins(coins), .buttons(buttons),
    .cancel(cancel), .item(item), .count(count), .cost(cost), .valid(valid),
    .product(product), .status(status), .balance(balance),
    .change_valid(change_valid), .credit(credit), .info(info),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: every coin-return strobe must match the oldest expectation
  always @(negedge clk) begin
    if (hrst_n) begin
      if (change_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_cv", change_valid, 0);
        else chk("sb_return", {product, balance}, exp_q.pop_front());
      end else if (product != '0 || balance != '0) begin
        chk("idle_outputs", {product, balance}, 0);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ret(input int p, input int b);
    exp_q.push_back({SEL_W'(p), BAL_W'(b)});
  endtask

  task automatic restock(input int it, input int cnt, input int cst,
                         input int exp_st, input int exp_info);
    item = SEL_W'(it); count = 4'(cnt); cost = 8'(cst); valid = 1'b1;
    tick(1);
    valid = 1'b0;
    chk("restock_status", status, exp_st);
    chk("restock_info", info, exp_info);
    tick(1);
  endtask

  task automatic press(input int b, input int exp_st, input int exp_info);
    buttons = SEL_W'(b);
    tick(1);
    buttons = '0;
    tick(1);
    chk("press_status", status, exp_st);
    chk("press_info", info, exp_info);
  endtask

  task automatic coin(input logic [1:0] c);
    coins = c;
    tick(1);
    coins = 2'b00;
  endtask

  task automatic check_all_zero();
    chk("rst_product", product, 0);
    chk("rst_status", status, 0);
    chk("rst_balance", balance, 0);
    chk("rst_cv", change_valid, 0);
    chk("rst_credit", credit, 0);
    chk("rst_info", info, 0);
    chk("rst_state", dbg_state, 0);
  endtask

  initial begin
    int n;
    hrst_n = 1'b0;
    tick(3);
    hrst_n = 1'b1;
    check_all_zero();

    // basic purchase, exact price
    restock(2, 3, 50, 0, 3);
    press(2, 1, 3);
    coin(2'b11);
    chk("credit_q1", credit, 25);
    expect_ret(2, 0);
    coin(2'b11);
    chk("credit_q2", credit, 50);
    tick(1);
    chk("vend_state", dbg_state, 3);
    tick(1);
    chk("vend_product", product, 2);
    chk("vend_status", status, 0);
    chk("vend_credit_clr", credit, 0);

    // late coin on the vend decision cycle is dropped
    restock(3, 5, 35, 0, 5);
    press(3, 1, 5);
    coin(2'b11);
    coin(2'b10);
    chk("credit_35", credit, 35);
    expect_ret(3, 0);
    coin(2'b11);
    chk("late_coin_ignored", credit, 35);
    tick(1);
    chk("vend3_product", product, 3);
    chk("vend3_credit_clr", credit, 0);

    // out of stock and unpriced items
    press(4, 2, 0);
    chk("oos_state", dbg_state, 0);
    restock(5, 2, 0, 0, 2);
    press(5, 2, 2);
    tick(4);

    // button beyond the item range
    buttons = 4'd9;
    tick(1);
    buttons = '0;
    chk("bad_button_status", status, 3);
    chk("bad_button_state", dbg_state, 0);

    // inactivity timeout after a dime; stock of item 2 dropped to 2
    press(2, 1, 2);
    expect_ret(0, 10);
    coin(2'b10);
    n = 0;
    for (int i = 1; i <= TIMEOUT + 20; i++) begin
      tick(1);
      if (change_valid) begin
        n = i;
        break;
      end
    end
    chk("timeout_latency", n, TIMEOUT + 1);
    chk("timeout_balance", balance, 10);

    // cancel with a nickel in the same cycle
    press(2, 1, 2);
    coin(2'b10);
    expect_ret(0, 15);
    coins = 2'b01; cancel = 1'b1;
    tick(1);
    coins = 2'b00; cancel = 1'b0;
    chk("cancel_credit", credit, 15);
    tick(1);
    chk("cancel_cv", change_valid, 1);
    chk("cancel_credit_clr", credit, 0);

    // restock limits
    restock(6, 10, 20, 0, 10);
    restock(6, 6, 0, 3, 10);
    restock(6, 5, 0, 0, 15);
    restock(9, 1, 10, 3, 15);
    restock(6, 1, 40, 3, 15);
    press(6, 1, 15);
    coin(2'b11);
    chk("price40_credit", credit, 25);
    expect_ret(6, 10);
    coin(2'b11);
    tick(2);

    // back-to-back supplier writes
    item = 4'd7; count = 4'd2; cost = 8'd30; valid = 1'b1;
    tick(1);
    chk("b2b_info1", info, 2);
    count = 4'd3; cost = 8'd0;
    tick(1);
    chk("b2b_info2", info, 5);
    chk("b2b_status", status, 0);
    valid = 1'b0;
    tick(1);

    // soft reset mid-collect: no refund, tables kept
    press(7, 1, 5);
    coin(2'b11);
    chk("srst_pre_credit", credit, 25);
    srst = 1'b1;
    tick(1);
    srst = 1'b0;
    chk("srst_credit", credit, 0);
    chk("srst_status", status, 0);
    chk("srst_state", dbg_state, 0);
    chk("srst_info_kept", info, 5);
    tick(3);
    press(7, 1, 5);
    expect_ret(0, 0);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    tick(2);

    // hard reset clears stock and prices
    hrst_n = 1'b0;
    tick(2);
    hrst_n = 1'b1;
    check_all_zero();
    press(7, 2, 0);
    restock(7, 1, 0, 0, 1);
    press(7, 2, 1);

    tick(3);
    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
